// File: rtl/elastic_operator.sv
// elastic_operator
//   Elastic arithmetic stage: gathers one operand per input channel through a
//   req/ack handshake, combines them with OP, and stores the result in a small
//   FIFO that is read independently by OUTPUT_SIZE consumers. An entry is only
//   reusable once every consumer has taken it.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   req_l       per-operand request to upstream (registered ~has)
//   ack_l       per-operand one-cycle data-valid pulse from upstream
//   din         operands, slice i = din[DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]
//   req_r       per-consumer request level
//   ack_r       per-consumer one-cycle result-valid pulse
//   dout        per-consumer result, held while ack_r[j] is low
//   fire_count  fires since reset, only present when ELASTIC_OPERATOR_STATS_EN
//               is defined

module elastic_operator #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    INPUT_SIZE  = 2,
    parameter int                    OUTPUT_SIZE = 2,
    parameter int                    DEPTH       = 4,
    parameter string                 OP          = "add",
    parameter logic [DATA_WIDTH-1:0] IMMEDIATE   = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic [INPUT_SIZE-1:0]             req_l,
    input  logic [INPUT_SIZE-1:0]             ack_l,
    input  logic [DATA_WIDTH*INPUT_SIZE-1:0]  din,
    input  logic [OUTPUT_SIZE-1:0]            req_r,
    output logic [OUTPUT_SIZE-1:0]            ack_r,
    output logic [DATA_WIDTH*OUTPUT_SIZE-1:0] dout
`ifdef ELASTIC_OPERATOR_STATS_EN
    ,
    output logic [31:0]                       fire_count
`endif
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

    logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0]  w_din;
    logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0]  r_opnd;
    logic [INPUT_SIZE-1:0]                  r_has;
    logic [INPUT_SIZE-1:0]                  r_req_l;
    logic [INPUT_SIZE-1:0]                  w_cap;
    logic [DATA_WIDTH-1:0]                  w_result;
    logic                                   w_fire;
    logic                                   w_full;
    logic [DATA_WIDTH-1:0]                  r_mem [DEPTH];
    logic [AW:0]                            r_wptr;
    logic [AW:0]                            r_rptr [OUTPUT_SIZE];
    logic [AW:0]                            w_occ [OUTPUT_SIZE];
    logic [OUTPUT_SIZE-1:0]                 w_rd;
    logic [OUTPUT_SIZE-1:0]                 r_ack_r;
    logic [OUTPUT_SIZE-1:0][DATA_WIDTH-1:0] r_dout;

    assign w_din  = din;
    assign w_cap  = ack_l & ~r_has;
    // Operands come from registers, so a capture can fire no earlier than the
    // following edge.
    assign w_fire = (&r_has) && !w_full;
    assign req_l  = r_req_l;
    assign ack_r  = r_ack_r;
    assign dout   = r_dout;

    generate
        if (OP == "pass") begin : g_pass
            assign w_result = r_opnd[0];
        end else if (OP == "addi") begin : g_addi
            assign w_result = r_opnd[0] + IMMEDIATE;
        end else if (OP == "subi") begin : g_subi
            assign w_result = r_opnd[0] - IMMEDIATE;
        end else if (OP == "muli") begin : g_muli
            assign w_result = r_opnd[0] * IMMEDIATE;
        end else if (OP == "sub") begin : g_sub
            always_comb begin
                w_result = r_opnd[0];
                for (int i = 1; i < INPUT_SIZE; i++)
                    w_result = w_result - r_opnd[i];
            end
        end else if (OP == "mul") begin : g_mul
            always_comb begin
                w_result = r_opnd[0];
                for (int i = 1; i < INPUT_SIZE; i++)
                    w_result = w_result * r_opnd[i];
            end
        end else begin : g_add
            always_comb begin
                w_result = r_opnd[0];
                for (int i = 1; i < INPUT_SIZE; i++)
                    w_result = w_result + r_opnd[i];
            end
        end
    endgenerate

    // Full when any consumer still owes DEPTH entries; pointers carry one
    // extra bit so full and empty are distinguishable after wrap.
    always_comb begin
        w_full = 1'b0;
        for (int j = 0; j < OUTPUT_SIZE; j++) begin
            w_occ[j] = r_wptr - r_rptr[j];
            w_rd[j]  = req_r[j] && (w_occ[j] != '0) && !r_ack_r[j];
            if (w_occ[j] == OCC_FULL)
                w_full = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < INPUT_SIZE; i++)
            if (w_cap[i])
                r_opnd[i] <= w_din[i];
    end

    always_ff @(posedge clk) begin
        if (w_fire)
            r_mem[r_wptr[AW-1:0]] <= w_result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_has   <= '0;
            r_req_l <= '0;
            r_wptr  <= '0;
            r_ack_r <= '0;
            r_dout  <= '0;
            for (int j = 0; j < OUTPUT_SIZE; j++)
                r_rptr[j] <= '0;
        end else begin
            r_req_l <= ~r_has;
            // Capture and fire never overlap: fire needs every has bit set.
            if (w_fire) begin
                r_has  <= '0;
                r_wptr <= r_wptr + PTR_ONE;
            end else begin
                r_has <= r_has | w_cap;
            end
            for (int j = 0; j < OUTPUT_SIZE; j++) begin
                r_ack_r[j] <= w_rd[j];
                if (w_rd[j]) begin
                    r_dout[j] <= r_mem[r_rptr[j][AW-1:0]];
                    r_rptr[j] <= r_rptr[j] + PTR_ONE;
                end
            end
        end
    end

`ifdef ELASTIC_OPERATOR_STATS_EN
    logic [31:0] r_fire_count;

    always_ff @(posedge clk) begin
        if (rst)
            r_fire_count <= '0;
        else if (w_fire)
            r_fire_count <= r_fire_count + 32'd1;
    end

    assign fire_count = r_fire_count;
`endif

endmodule

// File: tb/tb_elastic_operator.sv
// Bench for elastic_operator: an add/2-in/2-out instance, an addi/1-in
// instance and a sub/3-in/1-out instance sharing clock and reset.

module tb_elastic_operator;

    localparam int LIM = 100;

    typedef logic [31:0] q_t[$];

    logic        clk;
    logic        rst;

    logic [1:0]  a_req_l, a_ack_l, a_req_r, a_ack_r;
    logic [63:0] a_din, a_dout;
    logic [0:0]  b_req_l, b_ack_l;
    logic [1:0]  b_req_r, b_ack_r;
    logic [31:0] b_din;
    logic [63:0] b_dout;
    logic [2:0]  c_req_l, c_ack_l;
    logic [0:0]  c_req_r, c_ack_r;
    logic [95:0] c_din;
    logic [31:0] c_dout;
`ifdef ELASTIC_OPERATOR_STATS_EN
    logic [31:0] a_fire_count, b_fire_count, c_fire_count;
`endif

    q_t qa0, qa1, qb0, qb1, qc0;
    int n_checks = 0;
    int n_errors = 0;

    elastic_operator #(.DATA_WIDTH(32), .INPUT_SIZE(2), .OUTPUT_SIZE(2), .DEPTH(4), .OP("add")) u_a (
        .clk(clk), .rst(rst), .req_l(a_req_l), .ack_l(a_ack_l), .din(a_din),
        .req_r(a_req_r), .ack_r(a_ack_r), .dout(a_dout)
`ifdef ELASTIC_OPERATOR_STATS_EN
        , .fire_count(a_fire_count)
`endif
    );

    elastic_operator #(.DATA_WIDTH(32), .INPUT_SIZE(1), .OUTPUT_SIZE(2), .DEPTH(4), .OP("addi"),
                       .IMMEDIATE(32'd2)) u_b (
        .clk(clk), .rst(rst), .req_l(b_req_l), .ack_l(b_ack_l), .din(b_din),
        .req_r(b_req_r), .ack_r(b_ack_r), .dout(b_dout)
`ifdef ELASTIC_OPERATOR_STATS_EN
        , .fire_count(b_fire_count)
`endif
    );

    elastic_operator #(.DATA_WIDTH(32), .INPUT_SIZE(3), .OUTPUT_SIZE(1), .DEPTH(2), .OP("sub")) u_c (
        .clk(clk), .rst(rst), .req_l(c_req_l), .ack_l(c_ack_l), .din(c_din),
        .req_r(c_req_r), .ack_r(c_ack_r), .dout(c_dout)
`ifdef ELASTIC_OPERATOR_STATS_EN
        , .fire_count(c_fire_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic take(input string tag, ref q_t q, input logic [31:0] obs);
        logic [31:0] exp;
        chk({tag, "_avail"}, 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
            exp = q.pop_front();
            chk(tag, obs, exp);
        end
    endtask

    task automatic wait_empty(input string tag, ref q_t q);
        for (int t = 0; t < 20 * LIM && q.size() != 0; t++)
            @(negedge clk);
        chk(tag, 32'(q.size()), 32'd0);
    endtask

    task automatic send_a(input logic [31:0] x, input logic [31:0] y);
        for (int t = 0; t < LIM && a_req_l !== 2'b11; t++)
            @(negedge clk);
        chk("a_req_l_up", 32'(a_req_l), 32'h3);
        a_din   = {y, x};
        a_ack_l = 2'b11;
        qa0.push_back(x + y);
        qa1.push_back(x + y);
        @(negedge clk);
        a_ack_l = 2'b00;
        @(negedge clk);
    endtask

    task automatic send_b(input logic [31:0] x);
        for (int t = 0; t < LIM && b_req_l !== 1'b1; t++)
            @(negedge clk);
        chk("b_req_l_up", 32'(b_req_l), 32'h1);
        b_din   = x;
        b_ack_l = 1'b1;
        qb0.push_back(x + 32'd2);
        qb1.push_back(x + 32'd2);
        @(negedge clk);
        b_ack_l = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_c(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        for (int t = 0; t < LIM && c_req_l !== 3'b111; t++)
            @(negedge clk);
        chk("c_req_l_up", 32'(c_req_l), 32'h7);
        c_din   = {z, y, x};
        c_ack_l = 3'b111;
        qc0.push_back(x - y - z);
        @(negedge clk);
        c_ack_l = 3'b000;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (a_ack_r[0] === 1'b1) take("a_c0", qa0, a_dout[31:0]);
        if (a_ack_r[1] === 1'b1) take("a_c1", qa1, a_dout[63:32]);
        if (b_ack_r[0] === 1'b1) take("b_c0", qb0, b_dout[31:0]);
        if (b_ack_r[1] === 1'b1) take("b_c1", qb1, b_dout[63:32]);
        if (c_ack_r[0] === 1'b1) take("c_c0", qc0, c_dout);
    end

    initial begin
        rst     = 1'b1;
        a_ack_l = '0; a_req_r = '0; a_din = '0;
        b_ack_l = '0; b_req_r = 2'b11; b_din = '0;
        c_ack_l = '0; c_req_r = 1'b1; c_din = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_a_req_l", 32'(a_req_l), 32'h0);
        chk("rst_a_ack_r", 32'(a_ack_r), 32'h0);
        chk("rst_a_dout0", a_dout[31:0], 32'h0);
        chk("rst_a_dout1", a_dout[63:32], 32'h0);
        chk("rst_c_req_l", 32'(c_req_l), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_a_req_l", 32'(a_req_l), 32'h3);
        chk("rel_b_req_l", 32'(b_req_l), 32'h1);
        chk("rel_c_req_l", 32'(c_req_l), 32'h7);

        // basic add, including modulo wrap
        a_req_r = 2'b11;
        send_a(32'd5, 32'd7);
        send_a(32'hFFFF_FFFF, 32'd2);
        send_a(32'd100, 32'd200);
        send_a(32'h8000_0000, 32'h8000_0000);
        wait_empty("a_drain0_c0", qa0);
        wait_empty("a_drain0_c1", qa1);

        // consumer 1 stalled: FIFO fills after DEPTH results
        a_req_r = 2'b01;
        for (int i = 1; i <= 5; i++)
            send_a(32'(i), 32'(10 * i));
        repeat (10) begin
            @(negedge clk);
            chk("full_req_l_low", 32'(a_req_l), 32'h0);
        end
        chk("full_c0_pending", 32'(qa0.size()), 32'd1);
        chk("full_c1_pending", 32'(qa1.size()), 32'd5);
        a_req_r = 2'b11;
        for (int t = 0; t < LIM && a_req_l !== 2'b11; t++)
            @(negedge clk);
        chk("full_release", 32'(a_req_l), 32'h3);
        wait_empty("a_drain1_c0", qa0);
        wait_empty("a_drain1_c1", qa1);

        // reset with three entries pending
        a_req_r = 2'b00;
        send_a(32'd1, 32'd1);
        send_a(32'd2, 32'd2);
        send_a(32'd3, 32'd3);
        repeat (3) @(negedge clk);
        rst     = 1'b1;
        a_req_r = 2'b11;
        qa0.delete();
        qa1.delete();
        @(negedge clk);
        chk("midrst_ack_r", 32'(a_ack_r), 32'h0);
        chk("midrst_dout0", a_dout[31:0], 32'h0);
        chk("midrst_req_l", 32'(a_req_l), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rel_req_l", 32'(a_req_l), 32'h3);
        repeat (10) @(negedge clk);
        send_a(32'd20, 32'd22);
        wait_empty("a_drain2_c0", qa0);
        wait_empty("a_drain2_c1", qa1);

        // three-operand subtract
        send_c(32'd10, 32'd3, 32'd2);
        wait_empty("c_drain0", qc0);
`ifdef ELASTIC_OPERATOR_STATS_EN
        chk("c_fire_count_1", c_fire_count, 32'd1);
`endif
        send_c(32'd0, 32'd1, 32'd1);
        send_c(32'd100, 32'd50, 32'd25);
        wait_empty("c_drain1", qc0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
`ifdef ELASTIC_OPERATOR_STATS_EN
        chk("c_fire_count_rst", c_fire_count, 32'd0);
`endif
        chk("c_rst_ack_r", 32'(c_ack_r), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // long addi stream, pointer wrap on both consumers
        for (int i = 0; i < 5000; i++)
            send_b(32'(i));
        wait_empty("b_drain_c0", qb0);
        wait_empty("b_drain_c1", qb1);

        repeat (5) @(negedge clk);
        chk("end_qa", 32'(qa0.size() + qa1.size()), 32'd0);
        chk("end_qc", 32'(qc0.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
